// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit sitting after the execute-stage ALU.
// One memory transaction per instruction over a valid/ready request bus and a
// valid-only response bus; every instruction retires through a one-cycle
// writeback pulse. Non-memory instructions pass the ALU result through.
// Optional build macro: LSU_MISALIGN_CHECK_EN traps misaligned accesses at
// accept instead of issuing them (misalign_o is tied low otherwise).
module ysyx_22040125_lsu #(
   parameter int ADDR_W = 32,
   parameter int XLEN   = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic              ex_is_load_i,
   input  logic              ex_is_store_i,
   input  logic [1:0]        ex_size_i,
   input  logic              ex_unsigned_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   input  logic [XLEN-1:0]   ex_alu_result_i,
   input  logic [4:0]        ex_rd_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic              mem_req_wen_o,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic [XLEN-1:0]   mem_req_wdata_o,
   output logic [7:0]        mem_req_wmask_o,
   input  logic              mem_resp_valid_i,
   input  logic [XLEN-1:0]   mem_resp_rdata_i,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              misalign_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic [2:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;
   logic              req_valid_q, req_valid_d;
   logic              req_wen_q, req_wen_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
   logic [7:0]        req_wmask_q, req_wmask_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;

   logic              is_mem;
   logic              ex_misaligned;
   logic [7:0]        base_mask;
   logic [XLEN-1:0]   resp_shifted;
   logic [XLEN-1:0]   load_data;

   // Decode the incoming instruction: access width mask and alignment.
   always_comb begin
      is_mem = ex_is_load_i | ex_is_store_i;
      unique case (ex_size_i)
         2'b00:   begin base_mask = 8'h01; ex_misaligned = 1'b0;           end
         2'b01:   begin base_mask = 8'h03; ex_misaligned = ex_addr_i[0];   end
         2'b10:   begin base_mask = 8'h0F; ex_misaligned = |ex_addr_i[1:0]; end
         default: begin base_mask = 8'hFF; ex_misaligned = |ex_addr_i[2:0]; end
      endcase
   end

   // Align the returned 8-byte word to the access and sign/zero-extend it.
   always_comb begin
      resp_shifted = mem_resp_rdata_i >> {off_q, 3'b000};
      unique case (size_q)
         2'b00:   load_data = unsigned_q ? {56'd0, resp_shifted[7:0]}
                                         : {{56{resp_shifted[7]}}, resp_shifted[7:0]};
         2'b01:   load_data = unsigned_q ? {48'd0, resp_shifted[15:0]}
                                         : {{48{resp_shifted[15]}}, resp_shifted[15:0]};
         2'b10:   load_data = unsigned_q ? {32'd0, resp_shifted[31:0]}
                                         : {{32{resp_shifted[31]}}, resp_shifted[31:0]};
         default: load_data = resp_shifted;
      endcase
   end

`ifdef LSU_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   logic trap;
`endif

   // Next-state logic for the IDLE/REQ/WAIT controller and all held outputs.
   always_comb begin
      // NOTE: every _d starts from a default so no path leaves it unassigned
      // (which would infer a latch); wb_valid defaults low to make it a pulse.
      state_d     = state_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      off_d       = off_q;
      rd_d        = rd_q;
      req_valid_d = req_valid_q;
      req_wen_d   = req_wen_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      req_wmask_d = req_wmask_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign_d  = misalign_q;
      trap        = ex_valid_i & is_mem & ex_misaligned & (state_q == S_IDLE);
`endif

      unique case (state_q)
         S_IDLE: begin
            if (ex_valid_i) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = ex_rd_i;
                  wb_data_d  = ex_alu_result_i;
               end
`ifdef LSU_MISALIGN_CHECK_EN
               else if (trap) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = 5'd0;
                  wb_data_d  = XLEN'(ex_addr_i);
                  misalign_d = 1'b1;
               end
`endif
               else begin
                  size_d      = ex_size_i;
                  unsigned_d  = ex_unsigned_i;
                  off_d       = ex_addr_i[2:0];
                  rd_d        = ex_rd_i;
                  req_valid_d = 1'b1;
                  req_wen_d   = ~ex_is_load_i;  // load wins when both are set
                  req_addr_d  = {ex_addr_i[ADDR_W-1:3], 3'b000};
                  req_wdata_d = ex_wdata_i << {ex_addr_i[2:0], 3'b000};
                  req_wmask_d = base_mask << ex_addr_i[2:0];
                  state_d     = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_req_ready_i) begin
               req_valid_d = 1'b0;
               if (req_wen_q) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = 5'd0;
                  wb_data_d  = '0;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (mem_resp_valid_i) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = load_data;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

`ifdef LSU_MISALIGN_CHECK_EN
      if (wb_valid_d && !trap) misalign_d = 1'b0;
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before this edge.
      if (rst_i) begin
         state_q     <= S_IDLE;
         size_q      <= 2'd0;
         unsigned_q  <= 1'b0;
         off_q       <= 3'd0;
         rd_q        <= 5'd0;
         req_valid_q <= 1'b0;
         req_wen_q   <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         req_wmask_q <= 8'd0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         off_q       <= off_d;
         rd_q        <= rd_d;
         req_valid_q <= req_valid_d;
         req_wen_q   <= req_wen_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         req_wmask_q <= req_wmask_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
      end
   end

`ifdef LSU_MISALIGN_CHECK_EN
   // Misalign flag register, refreshed on every writeback pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
   assign misalign_o = misalign_q;
`else
   assign misalign_o = 1'b0;
`endif

   assign ex_ready_o      = (state_q == S_IDLE);
   assign mem_req_valid_o = req_valid_q;
   assign mem_req_wen_o   = req_wen_q;
   assign mem_req_addr_o  = req_addr_q;
   assign mem_req_wdata_o = req_wdata_q;
   assign mem_req_wmask_o = req_wmask_q;
   assign wb_valid_o      = wb_valid_q;
   assign wb_rd_o         = wb_rd_q;
   assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Self-checking bench for ysyx_22040125_lsu: directed cases followed by
// randomized transactions checked against a byte-level reference model.
module tb_ysyx_22040125_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_ready, ex_is_load, ex_is_store, ex_unsigned;
   logic [1:0]  ex_size;
   logic [31:0] ex_addr;
   logic [63:0] ex_wdata, ex_alu_result;
   logic [4:0]  ex_rd;
   logic        mem_req_valid, mem_req_ready, mem_req_wen;
   logic [31:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        wb_valid, misalign;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;

   int n_checks = 0;
   int n_pass   = 0;

   ysyx_22040125_lsu dut (
      .clk_i(clk), .rst_i(rst),
      .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
      .ex_is_load_i(ex_is_load), .ex_is_store_i(ex_is_store),
      .ex_size_i(ex_size), .ex_unsigned_i(ex_unsigned),
      .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
      .ex_alu_result_i(ex_alu_result), .ex_rd_i(ex_rd),
      .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
      .mem_req_wen_o(mem_req_wen), .mem_req_addr_o(mem_req_addr),
      .mem_req_wdata_o(mem_req_wdata), .mem_req_wmask_o(mem_req_wmask),
      .mem_resp_valid_i(mem_resp_valid), .mem_resp_rdata_i(mem_resp_rdata),
      .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
      .misalign_o(misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference model: byte lanes touched by an access of 2**sz bytes at off.
   function automatic logic [7:0] ref_mask(input logic [1:0] sz, input logic [2:0] off);
      logic [7:0] m = '0;
      for (int i = 0; i < (1 << sz); i++)
         if (int'(off) + i < 8) m[int'(off) + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input logic [2:0] off);
      logic [63:0] r = '0;
      for (int j = 0; j < 8; j++)
         if (j >= int'(off)) r[8*j +: 8] = wd[8*(j - int'(off)) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic [2:0] off,
                                            input bit uns, input logic [63:0] rdata);
      int n = 1 << sz;
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++)
         if (int'(off) + i < 8) v[8*i +: 8] = rdata[8*(int'(off) + i) +: 8];
      if (!uns && n < 8 && v[8*n - 1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic bit ref_misaligned(input logic [1:0] sz, input logic [2:0] off);
      return (int'(off) % (1 << sz)) != 0;
   endfunction

   // One complete instruction. rdly: REQ cycles before ready; sdly: WAIT cycles
   // before the response. Junk ex_valid / early responses are driven while busy.
   task automatic do_op(input string nm, input bit ld, input bit st, input logic [1:0] sz,
                        input logic [31:0] addr, input bit uns, input logic [63:0] wd,
                        input logic [63:0] alu, input logic [4:0] rd, input int rdly,
                        input int sdly, input logic [63:0] rdata);
      bit is_mem = ld | st;
      bit is_st  = st & ~ld;
      logic [4:0]  exp_rd;
      logic [63:0] exp_data;
      bit trap = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      trap = is_mem && ref_misaligned(sz, addr[2:0]);
`endif
      check({nm, ".ready"}, 64'(ex_ready), 64'd1);
      ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_size = sz;
      ex_addr = addr; ex_unsigned = uns; ex_wdata = wd; ex_alu_result = alu; ex_rd = rd;
      tick();
      ex_valid = 1'b0;
      if (!is_mem || trap) begin
         exp_rd   = trap ? 5'd0 : rd;
         exp_data = trap ? 64'(addr) : alu;
         check({nm, ".mreq"}, 64'(mem_req_valid), 64'd0);
      end else begin
         for (int c = 0; c <= rdly; c++) begin
            check({nm, ".rv"}, 64'(mem_req_valid), 64'd1);
            check({nm, ".rwen"}, 64'(mem_req_wen), 64'(is_st));
            check({nm, ".raddr"}, 64'(mem_req_addr), 64'({addr[31:3], 3'b000}));
            if (is_st) begin
               check({nm, ".wmask"}, 64'(mem_req_wmask), 64'(ref_mask(sz, addr[2:0])));
               check({nm, ".wdata"}, mem_req_wdata, ref_wdata(wd, addr[2:0]));
            end
            check({nm, ".busy"}, 64'(ex_ready | wb_valid), 64'd0);
            ex_valid = ($urandom_range(0, 1) == 1);
            ex_is_load = $urandom_range(0, 1); ex_addr = $urandom;
            mem_resp_valid = ($urandom_range(0, 1) == 1);
            mem_resp_rdata = {$urandom, $urandom};
            mem_req_ready = (c == rdly);
            tick();
         end
         mem_req_ready = 1'b0; mem_resp_valid = 1'b0; ex_valid = 1'b0;
         check({nm, ".rdrop"}, 64'(mem_req_valid), 64'd0);
         if (is_st) begin
            exp_rd = 5'd0; exp_data = 64'd0;
         end else begin
            for (int c = 0; c <= sdly; c++) begin
               check({nm, ".wait"}, 64'(ex_ready | wb_valid), 64'd0);
               ex_valid = ($urandom_range(0, 1) == 1);
               mem_resp_valid = (c == sdly);
               mem_resp_rdata = (c == sdly) ? rdata : {$urandom, $urandom};
               tick();
            end
            mem_resp_valid = 1'b0; ex_valid = 1'b0;
            exp_rd = rd; exp_data = ref_load(sz, addr[2:0], uns, rdata);
         end
      end
      check({nm, ".wbv"}, 64'(wb_valid), 64'd1);
      check({nm, ".wbrd"}, 64'(wb_rd), 64'(exp_rd));
      check({nm, ".wbdata"}, wb_data, exp_data);
      check({nm, ".misal"}, 64'(misalign), 64'(trap));
      tick();
      check({nm, ".pulse"}, 64'(wb_valid), 64'd0);
      check({nm, ".hold"}, wb_data, exp_data);
   endtask

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
      ex_size = 2'd0; ex_unsigned = 1'b0; ex_addr = '0; ex_wdata = '0;
      ex_alu_result = '0; ex_rd = '0; mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst.ready", 64'(ex_ready), 64'd1);
      check("rst.mreq", 64'(mem_req_valid), 64'd0);
      check("rst.wen", 64'(mem_req_wen), 64'd0);
      check("rst.wbv", 64'(wb_valid), 64'd0);
      check("rst.misal", 64'(misalign), 64'd0);
      check("rst.addr", 64'(mem_req_addr), 64'd0);
      check("rst.wmask", 64'(mem_req_wmask), 64'd0);
      check("rst.wbdata", wb_data, 64'd0);

      do_op("alu", 0, 0, 2'd0, 32'h0, 0, 64'h0, 64'h1234, 5'd5, 0, 0, 64'h0);
      do_op("sb", 0, 1, 2'd0, 32'h8000_0003, 0, 64'h0000_0000_0000_00AB, 64'h0, 5'd7, 3, 0, 64'h0);
      do_op("lh", 1, 0, 2'd1, 32'h8000_0002, 0, 64'h0, 64'h0, 5'd3, 0, 0, 64'h0000_0000_8001_0000);
      do_op("lhu", 1, 0, 2'd1, 32'h8000_0002, 1, 64'h0, 64'h0, 5'd4, 1, 0, 64'h0000_0000_8001_0000);
      do_op("lwu", 1, 0, 2'd2, 32'h8000_0004, 1, 64'h0, 64'h0, 5'd9, 0, 3, 64'hF000_0000_0000_0000);
      do_op("ldst", 1, 1, 2'd3, 32'h8000_0010, 0, 64'h0, 64'h0, 5'd1, 0, 0, 64'hDEAD_BEEF_0123_4567);
      do_op("lw_mis", 1, 0, 2'd2, 32'h8000_0002, 0, 64'h0, 64'h0, 5'd2, 0, 0, 64'h8877_6655_4433_2211);
      do_op("sd_mis", 0, 1, 2'd3, 32'h8000_0005, 0, 64'h1122_3344_5566_7788, 64'h0, 5'd2, 1, 0, 64'h0);

      // Reset while waiting for a load response; the late response is dropped.
      ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0; ex_size = 2'd3;
      ex_addr = 32'h8000_0008; ex_rd = 5'd6;
      tick();
      ex_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 64'h5555_AAAA_5555_AAAA;
      check("rstw.ready", 64'(ex_ready), 64'd1);
      check("rstw.mreq", 64'(mem_req_valid), 64'd0);
      tick();
      mem_resp_valid = 1'b0;
      check("rstw.late", 64'(wb_valid), 64'd0);
      check("rstw.ready2", 64'(ex_ready), 64'd1);

      // Reset while the request is still pending.
      ex_valid = 1'b1; ex_is_store = 1'b1; ex_is_load = 1'b0; ex_size = 2'd2; ex_addr = 32'h8000_0000;
      tick();
      ex_valid = 1'b0; rst = 1'b1;
      check("rstr.mreq_pre", 64'(mem_req_valid), 64'd1);
      tick();
      rst = 1'b0;
      check("rstr.mreq", 64'(mem_req_valid), 64'd0);
      check("rstr.ready", 64'(ex_ready), 64'd1);
      tick();
      check("rstr.wbv", 64'(wb_valid), 64'd0);

      for (int k = 0; k < 300; k++) begin
         int kind = $urandom_range(0, 3);
         do_op("rnd", kind == 1 || kind == 3, kind == 2 || kind == 3,
               2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) == 1,
               {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
               $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ysyx_22040125_lsu.md
Name: ysyx_22040125_lsu

Overview:
Load/store unit placed directly downstream of the execute-stage ALU. Consumes the ALU's 32-bit effective address, lane-replicated store data and 64-bit result. Performs one memory transaction per instruction over a valid/ready request and valid-only response bus, then emits a one-cycle writeback pulse. Non-memory instructions pass the ALU result through with one cycle of latency.

Parameters:
ADDR_W, 32, effective address width
XLEN, 64, data path width; fixed at 64, 8 byte lanes

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ex_valid  in  1  instruction offered by execute stage
ex_ready  out  1  LSU can accept; high only in IDLE
ex_is_load  in  1  load instruction
ex_is_store  in  1  store instruction
ex_size  in  2  00 byte, 01 half, 10 word, 11 double
ex_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
ex_addr  in  ADDR_W  effective address from ALU
ex_wdata  in  XLEN  store data, possibly lane-replicated
ex_alu_result  in  XLEN  ALU result for non-memory instructions
ex_rd  in  5  destination register
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  1 store, 0 load
mem_req_addr  out  ADDR_W  8-byte aligned address {ex_addr[ADDR_W-1:3],3'b0}
mem_req_wdata  out  XLEN  lane-aligned store data
mem_req_wmask  out  8  byte-enable mask
mem_resp_valid  in  1  load data valid
mem_resp_rdata  in  XLEN  load data, full 8-byte word
wb_valid  out  1  one-cycle retire pulse
wb_rd  out  5  destination register; 0 for stores
wb_data  out  XLEN  writeback data
misalign  out  1  misaligned-access flag, qualified by wb_valid

Behaviour:
- Reset: state IDLE; mem_req_valid, mem_req_wen, wb_valid, misalign = 0; mem_req_addr/wdata/wmask, wb_rd, wb_data = 0.
- States: IDLE, REQ, WAIT.
- IDLE: ex_ready=1. Accept on ex_valid.
  - Non-memory: latch ex_alu_result and ex_rd; wb_valid next cycle; stay IDLE.
  - Memory: latch size, unsigned, addr[2:0], rd; register request fields; go REQ.
  - ex_is_load and ex_is_store both set: treat as load.
- REQ: mem_req_valid=1. All mem_req_* fields are held stable until mem_req_ready.
  - Handshake as a store: go IDLE; wb_valid next cycle with wb_rd=0, wb_data=0.
  - Handshake as a load: go WAIT.
- WAIT: on mem_resp_valid, extract the load data and register it; wb_valid next cycle; go IDLE.
- mem_resp_valid outside WAIT is ignored.
- Latency:
  - Non-memory: wb_valid 1 cycle after accept.
  - Store: accept, REQ, wb_valid. Minimum 2 cycles.
  - Load: REQ, ≥1 WAIT cycle, wb_valid. Minimum 3 cycles.
- wmask: base = 01/03/0F/FF for b/h/w/d; wmask = (base << addr[2:0]) truncated to 8 bits.
- wdata: ex_wdata << (8*addr[2:0]), truncated to 64 bits; correct with or without replication.
- Load extract: s = mem_resp_rdata >> (8*addr[2:0]).
  - Take low 8/16/32/64 bits.
  - Sign-extend unless unsigned is set; unsigned has no effect on double.
- wb_valid is a one-cycle pulse with no backpressure; wb_rd/wb_data are held until the next pulse.
- Reset in REQ/WAIT: transaction dropped; IDLE and mem_req_valid=0 on the next cycle; a late response is ignored.
- Misaligned: half addr[0]!=0; word addr[1:0]!=0; double addr[2:0]!=0; byte never.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: a misaligned memory op is detected at accept and no request is issued. State stays IDLE. Next cycle: wb_valid=1, misalign=1, wb_rd=0, wb_data=zero-extended ex_addr.
- Undefined: misalign tied 0. Misaligned ops are issued; bytes beyond lane 7 are dropped by mask/shift truncation, and a load returns only in-lane bytes.

Test Plan:
- Non-memory: ex_alu_result=64'h1234, rd=5 → one cycle later wb_valid=1, wb_rd=5, wb_data=64'h1234.
- Store byte, addr=0x80000003, wdata=64'h...AB, ready held low 3 cycles → req fields stable throughout; wmask=8'h08, wdata[31:24]=8'hAB, req_addr=0x80000000; wb_valid with wb_rd=0 the cycle after handshake.
- Load half signed, addr offset 2, rdata=64'h0000_0000_8001_0000 → wb_data=64'hFFFF_FFFF_FFFF_8001; unsigned variant → 64'h8001.
- Load word unsigned, addr offset 4, rdata=64'hF000_0000_0000_0000, response 4 cycles after handshake → wb_data=64'hF000_0000, ex_ready low until return to IDLE.
- rst asserted in WAIT, then mem_resp_valid arrives → no wb_valid; IDLE with ex_ready=1 after reset releases.
- LSU_MISALIGN_CHECK_EN defined, load word addr=0x80000002 → mem_req_valid never set; next cycle wb_valid=1, misalign=1, wb_data=64'h80000002.
